bsg_arb_resp_router: RTL and testbench

- Companion to the fixed-priority arbiter; sits on the return path of a shared resource.
- On each accepted request, converts the arbiter's one-hot grant vector to a binary client id and queues it in order.
- Routes each in-order response from the shared resource back to the client that issued the request.
- Drives the arbiter's ready input with backpressure when the outstanding-request queue is full.

---
 rtl/bsg_arb_resp_router.sv | 103 ++++++++++
 tb/tb_bsg_arb_resp_router.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_arb_resp_router.sv
// bsg_arb_resp_router: queues arbiter grant ids in order and routes in-order responses back to the issuing client.
// Optional sticky protocol-error flag enabled by defining BSG_ARB_RESP_ROUTER_ERROR_EN.
`default_nettype none

module bsg_arb_resp_router #(
  parameter int inputs_p     = 32,
  parameter int els_p        = 4,
  parameter int data_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [inputs_p-1:0]     grants_i,
  input  logic                    req_fire_i,
  output logic                    ready_o,
  input  logic                    resp_v_i,
  input  logic [data_width_p-1:0] resp_data_i,
  output logic                    resp_ready_o,
  output logic [inputs_p-1:0]     v_o,
  output logic [data_width_p-1:0] data_o,
  input  logic [inputs_p-1:0]     ready_i,
  output logic                    error_o
);

  localparam int lg_inputs = (inputs_p > 1) ? $clog2(inputs_p) : 1;
  localparam int ptr_w     = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w     = $clog2(els_p + 1);

  localparam logic [ptr_w-1:0]    ptr_last = ptr_w'(els_p - 1);
  localparam logic [cnt_w-1:0]    cnt_full = cnt_w'(els_p);
  localparam logic [inputs_p-1:0] one_hot0 = inputs_p'(1);

  logic [lg_inputs-1:0] mem [els_p];
  logic [ptr_w-1:0]     wr_ptr;
  logic [ptr_w-1:0]     rd_ptr;
  logic [cnt_w-1:0]     count;

  logic [lg_inputs-1:0] grant_id;
  logic                 grant_legal;
  logic [lg_inputs-1:0] head_id;
  logic                 empty;
  logic                 push;
  logic                 pop;

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < inputs_p; i++) begin
      if (grants_i[i]) grant_id = lg_inputs'(i);
    end
  end

  // A one-hot vector is non-zero and has no bit left after clearing its lowest set bit.
  assign grant_legal = (grants_i != '0) && ((grants_i & (grants_i - one_hot0)) == '0);

  assign empty   = (count == '0);
  assign ready_o = (count != cnt_full);
  assign head_id = mem[rd_ptr];

  assign v_o          = (resp_v_i && !empty) ? (one_hot0 << head_id) : '0;
  assign data_o       = resp_data_i;
  assign resp_ready_o = !empty && ready_i[head_id];

  assign push = req_fire_i && ready_o && grant_legal;
  assign pop  = resp_v_i && resp_ready_o;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= grant_id;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == ptr_last) ? '0 : wr_ptr + ptr_w'(1);
      if (pop)  rd_ptr <= (rd_ptr == ptr_last) ? '0 : rd_ptr + ptr_w'(1);
      case ({push, pop})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef BSG_ARB_RESP_ROUTER_ERROR_EN
  logic error_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      error_r <= 1'b0;
    end else if ((req_fire_i && !grant_legal) || (resp_v_i && empty)) begin
      error_r <= 1'b1;
    end
  end

  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_arb_resp_router.sv
// Scoreboard bench for bsg_arb_resp_router (inputs_p=32, els_p=4, data_width_p=32).
`default_nettype none

module tb_bsg_arb_resp_router;

`ifdef BSG_ARB_RESP_ROUTER_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int ELS = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] grants = '0;
  logic        fire = 1'b0;
  logic        ready_o;
  logic        resp_v = 1'b0;
  logic [31:0] resp_data = '0;
  logic        resp_ready_o;
  logic [31:0] v_o;
  logic [31:0] data_o;
  logic [31:0] ready = '1;
  logic        error_o;

  int          checks = 0;
  int          errors = 0;
  int unsigned sb[$];
  bit          model_err = 1'b0;

  bsg_arb_resp_router #(
    .inputs_p(32), .els_p(ELS), .data_width_p(32)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .grants_i(grants), .req_fire_i(fire),
    .ready_o(ready_o), .resp_v_i(resp_v), .resp_data_i(resp_data),
    .resp_ready_o(resp_ready_o), .v_o(v_o), .data_o(data_o),
    .ready_i(ready), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the queue model, then advance the model at the edge.
  task automatic cycle(input string tag);
    int unsigned head;
    logic [31:0] exp_v;
    logic        exp_rr, exp_rdy, legal, do_push, do_pop;
    #1;
    exp_rdy = (sb.size() != ELS);
    exp_rr  = 1'b0;
    exp_v   = '0;
    if (sb.size() != 0) begin
      head   = sb[0];
      exp_rr = ready[head];
      if (resp_v) exp_v = 32'd1 << head;
    end
    check({tag, "/ready_o"}, 64'(ready_o), 64'(exp_rdy));
    check({tag, "/resp_ready_o"}, 64'(resp_ready_o), 64'(exp_rr));
    check({tag, "/v_o"}, 64'(v_o), 64'(exp_v));
    check({tag, "/data_o"}, 64'(data_o), 64'(resp_data));
    check({tag, "/error_o"}, 64'(error_o), 64'(model_err));
    legal   = ($countones(grants) == 1);
    do_push = fire && exp_rdy && legal;
    do_pop  = resp_v && exp_rr;
    @(posedge clk);
    if (!reset_n) begin
      sb.delete();
      model_err = 1'b0;
    end else begin
      if (ERR_EN && ((fire && !legal) || (resp_v && sb.size() == 0))) model_err = 1'b1;
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        for (int i = 0; i < 32; i++) if (grants[i]) sb.push_back(i);
      end
    end
    #1;
  endtask

  task automatic push_id(input int id);
    grants = 32'd1 << id;
    fire   = 1'b1;
    cycle("push");
    fire   = 1'b0;
    grants = '0;
  endtask

  task automatic pop_exp(input int id, input logic [31:0] d);
    logic [31:0] exp_v;
    exp_v     = 32'd1 << id;
    resp_v    = 1'b1;
    resp_data = d;
    #1;
    check("route_v", 64'(v_o), 64'(exp_v));
    check("route_data", 64'(data_o), 64'(d));
    cycle("pop");
    resp_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset hold
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_resp_ready", 64'(resp_ready_o), 64'd0);
    check("rst_v", 64'(v_o), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    @(posedge clk);
    #1;

    // In-order routing
    push_id(2);
    push_id(31);
    pop_exp(2, 32'hA5A5_0001);
    pop_exp(31, 32'hA5A5_0002);
    #1;
    check("route_done_v", 64'(v_o), 64'd0);
    check("route_done_rr", 64'(resp_ready_o), 64'd0);

    // Full and wrap
    for (int i = 1; i <= 4; i++) push_id(i);
    check("full_ready", 64'(ready_o), 64'd0);
    grants = 32'h20;
    fire   = 1'b1;
    cycle("fire_full");
    fire   = 1'b0;
    grants = '0;
    pop_exp(1, 32'h1111_0001);
    check("after_pop_ready", 64'(ready_o), 64'd1);
    push_id(5);
    check("refull_ready", 64'(ready_o), 64'd0);
    for (int i = 2; i <= 5; i++) pop_exp(i, 32'h2222_0000 + 32'(i));

    // Simultaneous push and pop
    push_id(8);
    push_id(9);
    grants    = 32'd1 << 7;
    fire      = 1'b1;
    resp_v    = 1'b1;
    resp_data = 32'h3333_0008;
    #1;
    check("simul_v", 64'(v_o), 64'(32'd1 << 8));
    cycle("simul");
    fire   = 1'b0;
    grants = '0;
    resp_v = 1'b0;
    pop_exp(9, 32'h3333_0009);
    pop_exp(7, 32'h3333_0007);
    #1;
    check("simul_empty_rr", 64'(resp_ready_o), 64'd0);

    // Backpressure
    push_id(5);
    ready     = ~32'h20;
    resp_v    = 1'b1;
    resp_data = 32'h4444_0005;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_v", 64'(v_o), 64'h20);
      check("bp_rr", 64'(resp_ready_o), 64'd0);
      cycle("bp");
    end
    ready = '1;
    pop_exp(5, 32'h4444_0005);

    // Illegal grant
    grants = 32'h3;
    fire   = 1'b1;
    cycle("bad_grant");
    fire   = 1'b0;
    grants = '0;
    check("bad_grant_err", 64'(error_o), 64'(ERR_EN));
    check("bad_grant_nopush", 64'(resp_ready_o), 64'd0);
    repeat (3) cycle("err_hold");
    check("err_sticky", 64'(error_o), 64'(ERR_EN));
    reset_n = 1'b0;
    cycle("err_rst");
    reset_n = 1'b1;
    check("err_cleared", 64'(error_o), 64'd0);

    // Response while empty
    resp_v    = 1'b1;
    resp_data = 32'hDEAD_0000;
    cycle("empty_resp");
    resp_v = 1'b0;
    check("empty_resp_err", 64'(error_o), 64'(ERR_EN));
    reset_n = 1'b0;
    cycle("rst2");
    reset_n = 1'b1;

    // Reset mid-operation discards queued ids
    push_id(3);
    push_id(4);
    reset_n = 1'b0;
    cycle("mid_rst");
    reset_n = 1'b1;
    #1;
    check("mid_rst_ready", 64'(ready_o), 64'd1);
    resp_v = 1'b1;
    #1;
    check("mid_rst_v", 64'(v_o), 64'd0);
    check("mid_rst_rr", 64'(resp_ready_o), 64'd0);
    resp_v = 1'b0;
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
